pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 85 ++++++++
 tb/tb_pipe_skid_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage: 1-cycle latency, 1 payload/cycle when downstream is ready.
// Back-pressure: the skid register catches the in-flight payload; in_ready_o is registered and drops once both entries are full.
module pipe_skid_stage #(
  parameter int W = 271
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   count_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t         state_q, state_nxt;
  logic [W-1:0]   main_q, main_nxt;
  logic [W-1:0]   skid_q, skid_nxt;
  logic           in_rdy_q, out_vld_q;
  logic [1:0]     cnt_q;
  logic           in_fire, out_fire;

  assign in_fire  = in_valid_i & in_rdy_q;
  assign out_fire = out_vld_q & out_ready_i;

  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_nxt  = in_data_i;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data_i;
        end else if (in_fire) begin
          skid_nxt  = in_data_i;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready_o is low here, so only a drain can happen
        if (out_fire) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      in_rdy_q  <= (state_nxt != FULL);
      out_vld_q <= (state_nxt != EMPTY);
      cnt_q     <= (state_nxt == FULL) ? 2'd2 : (state_nxt == ONE) ? 2'd1 : 2'd0;
    end
  end

  assign in_ready_o  = in_rdy_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = main_q;
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed scenarios plus a randomized run against a queue-based model of the stage.
module tb_pipe_skid_stage;
  localparam int W = 271;

  logic         clk = 1'b0;
  logic         rst, flush_i, in_valid_i, out_ready_i;
  logic [W-1:0] in_data_i;
  logic         in_ready_o, out_valid_o;
  logic [W-1:0] out_data_o;
  logic [1:0]   count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_skid_stage #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_payload();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; in_valid_i = 1'b1; in_data_i = W'(77);
    tick();
    rst = 1'b0; in_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid_o); end
    n_cmp++; if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_data got %0h want 0", out_data_o); end
    n_cmp++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", in_ready_o); end
  endtask

  task automatic test_streaming();
    idle_inputs();
    out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid_i = 1'b1; in_data_i = W'(k);
      tick();
      n_cmp++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b want 1", k, out_valid_o); end
      n_cmp++; if (out_data_o !== W'(k)) begin n_fail++; $display("FAIL stream_data[%0d] got %0h want %0h", k, out_data_o, k); end
      n_cmp++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want 1", k, count_o); end
      n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %0b want 1", k, in_ready_o); end
    end
    in_valid_i = 1'b0;
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %0b want 0", out_valid_o); end
    n_cmp++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", count_o); end
    n_cmp++; if (out_data_o !== W'(4)) begin n_fail++; $display("FAIL drain_hold got %0h want 4", out_data_o); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    a = rand_payload(); b = rand_payload(); c = rand_payload();
    idle_inputs();
    in_valid_i = 1'b1; in_data_i = a;
    tick();
    n_cmp++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL bp_count1 got %0d want 1", count_o); end
    n_cmp++; if (out_data_o !== a) begin n_fail++; $display("FAIL bp_dataA got %0h want %0h", out_data_o, a); end
    in_data_i = b;
    tick();
    n_cmp++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL bp_count2 got %0d want 2", count_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %0b want 0", in_ready_o); end
    in_data_i = c;
    tick();
    n_cmp++; if (out_data_o !== a) begin n_fail++; $display("FAIL bp_stable got %0h want %0h", out_data_o, a); end
    n_cmp++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL bp_nooverfill got %0d want 2", count_o); end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    n_cmp++; if (out_data_o !== b) begin n_fail++; $display("FAIL bp_dataB got %0h want %0h", out_data_o, b); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %0b want 1", in_ready_o); end
    n_cmp++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL bp_count_drain got %0d want 1", count_o); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", out_valid_o); end
    n_cmp++; if (out_data_o !== b) begin n_fail++; $display("FAIL bp_hold got %0h want %0h", out_data_o, b); end
  endtask

  task automatic fill_full();
    idle_inputs();
    in_valid_i = 1'b1; in_data_i = rand_payload();
    tick();
    in_data_i = rand_payload();
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    fill_full();
    n_cmp++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count got %0d want 2", count_o); end
    flush_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1; in_data_i = rand_payload();
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid_o); end
    n_cmp++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count_o); end
    n_cmp++; if (out_data_o !== '0) begin n_fail++; $display("FAIL flush_data got %0h want 0", out_data_o); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_nodeliver got %0b want 0", out_valid_o); end
  endtask

  task automatic test_reset_mid();
    fill_full();
    rst = 1'b1; flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = rand_payload();
    tick();
    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %0b want 0", out_valid_o); end
    n_cmp++; if (out_data_o !== '0) begin n_fail++; $display("FAIL rstmid_data got %0h want 0", out_data_o); end
    n_cmp++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", count_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %0b want 1", in_ready_o); end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] hold, exp_data;
    logic         inf, outf, fl;
    int           errs;
    errs = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = '0;
    for (int c = 0; c < 10000; c++) begin
      fl          = ($urandom_range(0, 99) < 3);
      flush_i     = fl;
      in_valid_i  = ($urandom_range(0, 99) < 60);
      out_ready_i = ($urandom_range(0, 99) < 60);
      in_data_i   = rand_payload();
      inf  = in_valid_i && (q.size() < 2);
      outf = out_ready_i && (q.size() > 0);
      tick();
      if (fl) begin
        q.delete();
        hold = '0;
      end else begin
        if (outf) hold = q.pop_front();
        if (inf) q.push_back(in_data_i);
      end
      exp_data = (q.size() > 0) ? q[0] : hold;
      n_cmp++; if (count_o !== 2'(q.size())) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_count cyc %0d got %0d want %0d", c, count_o, q.size()); end
      n_cmp++; if (out_valid_o !== (q.size() > 0)) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_valid cyc %0d got %0b want %0b", c, out_valid_o, q.size() > 0); end
      n_cmp++; if (in_ready_o !== (q.size() < 2)) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ready cyc %0d got %0b want %0b", c, in_ready_o, q.size() < 2); end
      n_cmp++; if (out_data_o !== exp_data) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_data cyc %0d got %0h want %0h", c, out_data_o, exp_data); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
